// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the EX-stage ALU issue path.
//   - ALU control codes driven on the ALU control/A/B interface
//   - MIPS opcode and R-type funct constants understood by the decoder
//   - alu_entry_t: one decoded, issue-ready ALU operation
//   - buf_state_e: occupancy state of the two-entry issue skid buffer
package alu_pkg;

    // Operand width carried in alu_entry_t; the top-level W must match this.
    localparam int ALU_W = 32;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instruction [5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [2:0]       control;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [4:0]       dest_idx;
        logic             dest_we;
    } alu_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational decode of opcode/funct/immediate into an
// ALU issue entry.
// Ports:
//   opcode, funct     - instruction fields [31:26] and [5:0]
//   rs_data, rt_data  - register operand values
//   imm16             - instruction [15:0]
//   rt_idx, rd_idx    - register indices used for the writeback target
//   entry             - decoded control code, operands and writeback info
//   illegal           - opcode (or R-type funct) is not supported
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [ALU_W-1:0] rs_data,
    input  logic [ALU_W-1:0] rt_data,
    input  logic [15:0]      imm16,
    input  logic [4:0]       rt_idx,
    input  logic [4:0]       rd_idx,
    output alu_entry_t       entry,
    output logic             illegal
);

    logic [ALU_W-1:0] imm_sext;
    logic [ALU_W-1:0] imm_zext;

    assign imm_sext = {{(ALU_W-16){imm16[15]}}, imm16};
    assign imm_zext = {{(ALU_W-16){1'b0}}, imm16};

    always_comb begin
        // Operand A is always rs; non-writing ops leave dest_idx at 0.
        entry          = '0;
        entry.a        = rs_data;
        illegal        = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                entry.b        = rt_data;
                entry.dest_idx = rd_idx;
                entry.dest_we  = 1'b1;
                case (funct)
                    FN_ADD:  entry.control = ALU_ADD;
                    FN_SUB:  entry.control = ALU_SUB;
                    FN_AND:  entry.control = ALU_AND;
                    FN_OR:   entry.control = ALU_OR;
                    FN_SLT:  entry.control = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW: begin
                entry.control  = ALU_ADD;
                entry.b        = imm_sext;
                entry.dest_idx = rt_idx;
                entry.dest_we  = 1'b1;
            end
            OP_SLTI: begin
                entry.control  = ALU_SLT;
                entry.b        = imm_sext;
                entry.dest_idx = rt_idx;
                entry.dest_we  = 1'b1;
            end
            OP_ANDI: begin
                entry.control  = ALU_AND;
                entry.b        = imm_zext;
                entry.dest_idx = rt_idx;
                entry.dest_we  = 1'b1;
            end
            OP_ORI: begin
                entry.control  = ALU_OR;
                entry.b        = imm_zext;
                entry.dest_idx = rt_idx;
                entry.dest_we  = 1'b1;
            end
            OP_SW: begin
                // Address generation only; the store itself writes no register.
                entry.control = ALU_ADD;
                entry.b       = imm_sext;
            end
            OP_BEQ: begin
                entry.control = ALU_SUB;
                entry.b       = rt_data;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: EX-stage issue buffer. Decodes incoming instructions into ALU
// control/operands and holds them in a two-entry skid buffer.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. out_valid and the alu_*/dest_* payload are
// registered and stay stable while out_valid=1 and out_ready=0. in_ready
// is registered (state != TWO), so no ready path crosses this block
// combinationally.
//
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   in_valid / in_ready        - upstream handshake
//   opcode, funct, imm16       - instruction fields
//   rs_data, rt_data           - register operand values
//   rt_idx, rd_idx             - register indices
//   flush                      - drop all buffered entries and any same-cycle input
//   out_valid / out_ready      - downstream handshake
//   alu_control, alu_a, alu_b  - ALU control code and operands
//   dest_idx, dest_we          - writeback register and enable
//   illegal_cnt                - saturating count of rejected instructions
module alu_issue
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [W-1:0]     rs_data,
    input  logic [W-1:0]     rt_data,
    input  logic [15:0]      imm16,
    input  logic [4:0]       rt_idx,
    input  logic [4:0]       rd_idx,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       alu_control,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [4:0]       dest_idx,
    output logic             dest_we,
    output logic [CNT_W-1:0] illegal_cnt
);

    buf_state_e       state_q, state_d;
    alu_entry_t       out_q;      // oldest entry, drives the ALU
    alu_entry_t       skid_q;     // second entry, valid only in ST_TWO
    alu_entry_t       dec_entry;
    logic             dec_illegal;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;      // upstream handshake completes
    logic take;        // accepted, legal and not flushed: enqueue
    logic drain;       // downstream handshake completes
    logic load_new;    // out_q <= decoded input
    logic load_skid;   // skid_q <= decoded input
    logic promote;     // out_q <= skid_q
    logic cnt_inc;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .imm16   (imm16),
        .rt_idx  (rt_idx),
        .rd_idx  (rd_idx),
        .entry   (dec_entry),
        .illegal (dec_illegal)
    );

    assign accept  = in_valid && in_ready_q;
    assign take    = accept && !dec_illegal && !flush;
    assign drain   = out_valid_q && out_ready;
    // A flushed input is discarded outright, so it is never counted.
    assign cnt_inc = accept && dec_illegal && !flush && (cnt_q != {CNT_W{1'b1}});

    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (take) begin
                        state_d  = ST_ONE;
                        load_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({take, drain})
                        2'b10: begin
                            state_d   = ST_TWO;
                            load_skid = 1'b1;
                        end
                        2'b01: state_d = ST_EMPTY;
                        // Simultaneous accept and drain: the new entry
                        // replaces the departing one directly.
                        2'b11: load_new = 1'b1;
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain side matters.
                    if (drain) begin
                        state_d = ST_ONE;
                        promote = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
            if (load_new) begin
                out_q <= dec_entry;
            end else if (promote) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_entry;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign alu_control = out_q.control;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign dest_idx    = out_q.dest_idx;
    assign dest_we     = out_q.dest_we;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: bench for alu_issue. A queue of expected entries models the
// buffer contents; the decode reference is a table from instruction to
// expected ALU operation.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  dest_idx;
    logic        dest_we;
    logic [7:0]  illegal_cnt;

    int total;
    int bad;

    // Expected buffer contents, oldest first: {ctl[72:70], a[69:38], b[37:6], dest[5:1], we[0]}
    logic [72:0] exp_q[$];
    logic        exp_ready;
    int          exp_cnt;

    alu_issue #(.W(32), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm16       (imm16),
        .rt_idx      (rt_idx),
        .rd_idx      (rd_idx),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .dest_idx    (dest_idx),
        .dest_we     (dest_we),
        .illegal_cnt (illegal_cnt)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- compare helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference decode ----------------
    // Returns {legal, ctl, a, b, dest, we}.
    function automatic logic [73:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                               input logic [31:0] rs, input logic [31:0] rt,
                                               input logic [15:0] im, input logic [4:0] ti,
                                               input logic [4:0] di);
        logic        legal;
        logic [2:0]  ctl;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] sx;
        logic [31:0] zx;
        sx    = 32'(signed'(im));
        zx    = 32'(im);
        legal = 1'b1;
        ctl   = 3'b000;
        b     = 32'h0;
        dest  = 5'd0;
        we    = 1'b0;
        case (op)
            6'b000000: begin
                b = rt; dest = di; we = 1'b1;
                case (fn)
                    6'b100000: ctl = 3'b010;
                    6'b100010: ctl = 3'b110;
                    6'b100100: ctl = 3'b000;
                    6'b100101: ctl = 3'b001;
                    6'b101010: ctl = 3'b111;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin ctl = 3'b010; b = sx; dest = ti; we = 1'b1; end
            6'b001010: begin ctl = 3'b111; b = sx; dest = ti; we = 1'b1; end
            6'b001100: begin ctl = 3'b000; b = zx; dest = ti; we = 1'b1; end
            6'b001101: begin ctl = 3'b001; b = zx; dest = ti; we = 1'b1; end
            6'b100011: begin ctl = 3'b010; b = sx; dest = ti; we = 1'b1; end
            6'b101011: begin ctl = 3'b010; b = sx; end
            6'b000100: begin ctl = 3'b110; b = rt; end
            default:   legal = 1'b0;
        endcase
        return {legal, ctl, rs, b, dest, we};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic [72:0] e;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("alu_control", 32'(alu_control), 32'(e[72:70]));
            chk("alu_a", alu_a, e[69:38]);
            chk("alu_b", alu_b, e[37:6]);
            chk("dest_we", 32'(dest_we), 32'(e[0]));
            if (e[0]) chk("dest_idx", 32'(dest_idx), 32'(e[5:1]));
        end
    endtask

    // Advance the model across one rising edge using the inputs driven now.
    task automatic model_update();
        logic [73:0] d;
        logic        drn;
        logic        acc;
        if (!rst_n) begin
            exp_q.delete();
            exp_ready = 1'b0;
            exp_cnt   = 0;
            return;
        end
        d   = ref_decode(opcode, funct, rs_data, rt_data, imm16, rt_idx, rd_idx);
        drn = (exp_q.size() != 0) && out_ready;
        acc = in_valid && exp_ready;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc && d[73]) exp_q.push_back(d[72:0]);
            if (acc && !d[73] && exp_cnt < 255) exp_cnt++;
        end
        exp_ready = (exp_q.size() < 2);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set between negedges; outputs are checked before the edge.
    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] im, input logic [4:0] ti,
                           input logic [4:0] di);
        opcode = op; funct = fn; rs_data = rs; rt_data = rt;
        imm16 = im; rt_idx = ti; rd_idx = di;
    endtask

    task automatic rand_instr(input int ill_pct);
        logic [5:0] op;
        logic [5:0] fn;
        fn = 6'($urandom_range(0, 63));
        if (int'($urandom_range(0, 99)) < ill_pct) begin
            case ($urandom_range(0, 3))
                0: op = 6'b111111;
                1: op = 6'b000010;
                2: op = 6'b001111;
                default: begin op = 6'b000000; fn = 6'b000001; end
            endcase
        end else begin
            case ($urandom_range(0, 11))
                0: begin op = 6'b000000; fn = 6'b100000; end
                1: begin op = 6'b000000; fn = 6'b100010; end
                2: begin op = 6'b000000; fn = 6'b100100; end
                3: begin op = 6'b000000; fn = 6'b100101; end
                4: begin op = 6'b000000; fn = 6'b101010; end
                5: op = 6'b001000;
                6: op = 6'b001010;
                7: op = 6'b001100;
                8: op = 6'b001101;
                9: op = 6'b100011;
                10: op = 6'b101011;
                default: op = 6'b000100;
            endcase
        end
        set_ins(op, fn, $urandom, $urandom, 16'($urandom), 5'($urandom), 5'($urandom));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int saved_cnt;
        total = 0; bad = 0;
        exp_ready = 1'b0; exp_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_ins(6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset values while rst_n is low
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_control", 32'(alu_control), 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_dest", 32'(dest_idx), 32'd0);
        chk("rst_we", 32'(dest_we), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // addi rs=5 imm=0xFFFF
        in_valid = 1'b1;
        set_ins(6'b001000, 6'd0, 32'd5, 32'd99, 16'hFFFF, 5'd9, 5'd3);
        cycle();
        in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_ctl", 32'(alu_control), 32'b010);
        chk("addi_a", alu_a, 32'd5);
        chk("addi_b", alu_b, 32'hFFFF_FFFF);
        chk("addi_dest", 32'(dest_idx), 32'd9);
        cycle();

        // slt stalled for 3 cycles, sub queued behind it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_ins(6'b000000, 6'b101010, 32'd3, 32'd7, 16'h0, 5'd2, 5'd4);
        cycle();
        set_ins(6'b000000, 6'b100010, 32'd20, 32'd8, 16'h0, 5'd2, 5'd6);
        cycle();
        in_valid = 1'b0;
        chk("two_in_ready", 32'(in_ready), 32'd0);
        chk("slt_held_ctl", 32'(alu_control), 32'b111);
        cycle();
        chk("slt_still_ctl", 32'(alu_control), 32'b111);
        out_ready = 1'b1;
        cycle();
        chk("sub_ctl", 32'(alu_control), 32'b110);
        chk("sub_a", alu_a, 32'd20);
        cycle();

        // andi zero-extension, sw, beq
        in_valid = 1'b1;
        set_ins(6'b001100, 6'd0, 32'hFFFF_FFFF, 32'd0, 16'h8001, 5'd1, 5'd0);
        cycle();
        chk("andi_b", alu_b, 32'h0000_8001);
        chk("andi_ctl", 32'(alu_control), 32'b000);
        set_ins(6'b101011, 6'd0, 32'h100, 32'd0, 16'hFFFC, 5'd7, 5'd0);
        cycle();
        chk("sw_we", 32'(dest_we), 32'd0);
        set_ins(6'b000100, 6'd0, 32'd11, 32'd12, 16'h0010, 5'd7, 5'd0);
        cycle();
        chk("beq_ctl", 32'(alu_control), 32'b110);
        chk("beq_we", 32'(dest_we), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Illegal instructions
        apply_reset();
        in_valid = 1'b1;
        set_ins(6'b111111, 6'd0, 32'd1, 32'd2, 16'd3, 5'd4, 5'd5);
        cycle();
        set_ins(6'b000000, 6'b000001, 32'd1, 32'd2, 16'd3, 5'd4, 5'd5);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("illegal_two_cnt", 32'(illegal_cnt), 32'd2);
        chk("illegal_no_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_instr(100);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("illegal_saturate", 32'(illegal_cnt), 32'd255);

        // Flush in TWO with a same-cycle input
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_instr(0);
        cycle();
        rand_instr(0);
        cycle();
        chk("flush_pre_two", 32'(in_ready), 32'd0);
        saved_cnt = int'(illegal_cnt);
        flush = 1'b1;
        set_ins(6'b111111, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_two_valid", 32'(out_valid), 32'd0);
        chk("flush_two_ready", 32'(in_ready), 32'd1);
        chk("flush_two_cnt", 32'(illegal_cnt), 32'(saved_cnt));

        // Flush in ONE while an illegal instruction is accepted: not counted
        in_valid = 1'b1;
        rand_instr(0);
        cycle();
        flush = 1'b1;
        set_ins(6'b000000, 6'b000001, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", 32'(out_valid), 32'd0);
        chk("flush_one_cnt", 32'(illegal_cnt), 32'(saved_cnt));
        cycle();

        // Back-to-back stream: no bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_instr(0);
            cycle();
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk("b2b_empty", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 4);
            rand_instr(15);
            cycle();
        end
        flush = 1'b0;

        // Reset with both entries occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_instr(0);
        cycle();
        rand_instr(0);
        cycle();
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
